// File: rtl/sram_port_adapter.sv
// Valid/ready front-end for a single-port byte-enabled sram with 1-cycle read latency.
// Read data is parked in a small response FIFO so the consumer can stall freely.
module sram_port_adapter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned RSP_DEPTH  = 3,
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic                  rd_room;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A read reserves a FIFO slot at issue, so a push can never overflow.
    assign rd_room     = ({1'b0, count} + {{CW{1'b0}}, inflight}) < DEPTH;
    assign req_ready_o = req_we_i | rd_room;

    assign sram_req_o   = req_valid_i & req_ready_o;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_we_i ? req_be_i : '0;

    assign push        = inflight;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_valid_o = (count != '0);
    assign rsp_rdata_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= sram_req_o & ~req_we_i;
            if (push) begin
                mem[wr_ptr] <= sram_rdata_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    no_full_push: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push && count == CW'(RSP_DEPTH))
    );

endmodule

// File: tb/tb_sram_port_adapter.sv
// Self-checking bench for sram_port_adapter with a behavioural sram and
// a queue-based reference of outstanding reads.
module tb_sram_port_adapter;

    localparam int DW    = 64;
    localparam int NW    = 1024;
    localparam int DEPTH = 3;
    localparam int AW    = 10;
    localparam int BW    = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [BW-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] smem   [NW];
    logic [DW-1:0] refmem [NW];
    logic [DW-1:0] expq [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_adapter #(
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    // Behavioural sram; rdata is garbage except in the cycle after a read.
    always @(posedge clk) begin
        if (sram_req && !sram_we) begin
            sram_rdata <= smem[sram_addr];
        end else begin
            sram_rdata <= {$urandom, $urandom};
        end
        if (sram_req && sram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_be[b]) smem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be,
                         input logic rr);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = rr;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    // One clock: sample outputs mid-cycle, update the reference on a handshake.
    task automatic tick(output logic rdy, output logic rv, output logic [DW-1:0] rd);
        @(negedge clk);
        rdy = req_ready;
        rv  = rsp_valid;
        rd  = rsp_rdata;
        if (req_valid && rdy) begin
            if (req_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (req_be[b]) refmem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end
            end else begin
                expq.push_back(refmem[req_addr]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle(1'b0);
        #12;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata);
        end
        checks++;
        if (sram_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_sram_req: got %b expected 0", sram_req);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        logic rdy, rv;
        logic [DW-1:0] rd, exp;
        drive(1'b1, 1'b0, 10'd5, {$urandom, $urandom}, 8'hFF, 1'b1);
        #1;
        checks++;
        if (sram_req !== 1'b1 || sram_be !== '0 || sram_addr !== 10'd5 || sram_we !== 1'b0) begin
            errors++;
            $display("FAIL single_sram_drive: got req=%b be=%h addr=%0d expected req=1 be=00 addr=5",
                     sram_req, sram_be, sram_addr);
        end
        tick(rdy, rv, rd);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got %b expected 1", rdy);
        end
        idle(1'b1);
        tick(rdy, rv, rd);
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: got rsp_valid %b expected 0", rv);
        end
        tick(rdy, rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 64'hA5A5 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: got v=%b d=%h rdy=%b expected v=1 d=a5a5 rdy=1", rv, rd, rdy);
        end
        if (expq.size() > 0) begin
            exp = expq.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL single_model: got %h expected %h", rd, exp);
            end
        end
    endtask

    task automatic test_streaming();
        logic rdy, rv;
        logic [DW-1:0] rd, exp;
        int k = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 16) drive(1'b1, 1'b0, AW'(c), '0, '0, 1'b1);
            else idle(1'b1);
            tick(rdy, rv, rd);
            if (c < 16) begin
                checks++;
                if (rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready c=%0d: got %b expected 1", c, rdy);
                end
            end
            if (rv) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious c=%0d: got rsp %h expected none", c, rd);
                end else begin
                    exp = expq.pop_front();
                    if (rd !== exp || rd !== refmem[k] || c != k + 2) begin
                        errors++;
                        $display("FAIL stream_rsp k=%0d: got %h at cycle %0d expected %h at cycle %0d",
                                 k, rd, c, exp, k + 2);
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 16", k);
        end
    endtask

    task automatic test_backpressure();
        logic rdy, rv, exp_rdy;
        logic [DW-1:0] rd, exp;
        int acc = 0;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = (expq.size() < DEPTH);
            drive(1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0, '0, 1'b0);
            tick(rdy, rv, rd);
            checks++;
            if (rdy !== exp_rdy) begin
                errors++;
                $display("FAIL bp_ready c=%0d: got %b expected %b", c, rdy, exp_rdy);
            end
            if (rdy) acc++;
        end
        checks++;
        if (acc != 3) begin
            errors++;
            $display("FAIL bp_accepted: got %0d expected 3", acc);
        end
        drive(1'b1, 1'b1, AW'($urandom_range(0, NW - 1)), {$urandom, $urandom},
              BW'($urandom), 1'b0);
        tick(rdy, rv, rd);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_write_ready: got %b expected 1", rdy);
        end
        for (int c = 0; c < 12; c++) begin
            exp_rdy = (expq.size() < DEPTH);
            if (c < 8) drive(1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0, '0, 1'b1);
            else idle(1'b1);
            tick(rdy, rv, rd);
            if (c < 8) begin
                checks++;
                if (rdy !== exp_rdy) begin
                    errors++;
                    $display("FAIL bp_release_ready c=%0d: got %b expected %b", c, rdy, exp_rdy);
                end
            end
            if (rv) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL bp_spurious c=%0d: got %h expected none", c, rd);
                end else begin
                    exp = expq.pop_front();
                    if (rd !== exp) begin
                        errors++;
                        $display("FAIL bp_rsp c=%0d: got %h expected %h", c, rd, exp);
                    end
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d left expected 0", expq.size());
        end
    endtask

    task automatic test_write_read();
        logic rdy, rv;
        logic [DW-1:0] rd, exp;
        int n = 0;
        drive(1'b1, 1'b1, 10'd7, 64'hDEADBEEF, 8'h0F, 1'b1);
        tick(rdy, rv, rd);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept: got %b expected 1", rdy);
        end
        drive(1'b1, 1'b0, 10'd7, '0, '0, 1'b1);
        tick(rdy, rv, rd);
        checks++;
        if (rdy !== 1'b1 || rv !== 1'b0) begin
            errors++;
            $display("FAIL wr_then_read: got rdy=%b rv=%b expected rdy=1 rv=0", rdy, rv);
        end
        idle(1'b1);
        for (int c = 0; c < 6; c++) begin
            tick(rdy, rv, rd);
            if (rv) begin
                n++;
                checks++;
                exp = (expq.size() > 0) ? expq.pop_front() : 'x;
                if (rd !== 64'h11223344DEADBEEF || rd !== exp || c != 1) begin
                    errors++;
                    $display("FAIL wr_rsp: got %h at %0d expected 11223344deadbeef at 1", rd, c);
                end
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL wr_rsp_count: got %0d expected 1", n);
        end
    endtask

    task automatic test_reset_mid();
        logic rdy, rv;
        logic [DW-1:0] rd;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, AW'($urandom_range(0, NW - 1)), '0, '0, 1'b0);
            tick(rdy, rv, rd);
        end
        idle(1'b0);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got rsp_valid %b expected 1", rsp_valid);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b d=%h expected v=0 d=0", rsp_valid, rsp_rdata);
        end
        expq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1);
        for (int c = 0; c < 4; c++) begin
            tick(rdy, rv, rd);
            checks++;
            if (rv !== 1'b0 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after c=%0d: got rv=%b rdy=%b expected rv=0 rdy=1", c, rv, rdy);
            end
        end
    endtask

    task automatic test_push_pop();
        logic rdy, rv;
        logic [DW-1:0] rd, exp;
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom_range(0, NW - 1));
        a1 = AW'($urandom_range(0, NW - 1));
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1'b1, 1'b0, a0, '0, '0, 1'b1);
            else if (c == 1) drive(1'b1, 1'b0, a1, '0, '0, 1'b1);
            else idle(1'b1);
            tick(rdy, rv, rd);
            checks++;
            if (rv !== (c == 2 || c == 3)) begin
                errors++;
                $display("FAIL pushpop_valid c=%0d: got %b expected %b", c, rv, (c == 2 || c == 3));
            end else if (rv) begin
                exp = expq.pop_front();
                if (rd !== exp || rd !== refmem[(c == 2) ? a0 : a1]) begin
                    errors++;
                    $display("FAIL pushpop_data c=%0d: got %h expected %h", c, rd, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic rdy, rv, exp_rdy, we, rr;
        logic [DW-1:0] rd, exp;
        for (int c = 0; c < 600; c++) begin
            we = 1'($urandom_range(0, 2) == 0);
            rr = 1'($urandom_range(0, 3) != 0);
            exp_rdy = we ? 1'b1 : (expq.size() < DEPTH);
            drive(1'($urandom), we, AW'($urandom_range(0, 15)), {$urandom, $urandom},
                  BW'($urandom), rr);
            tick(rdy, rv, rd);
            checks++;
            if (rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready c=%0d: got %b expected %b", c, rdy, exp_rdy);
            end
            if (rv && rr) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious c=%0d: got %h expected none", c, rd);
                end else begin
                    exp = expq.pop_front();
                    if (rd !== exp) begin
                        errors++;
                        $display("FAIL rand_rsp c=%0d: got %h expected %h", c, rd, exp);
                    end
                end
            end
        end
        idle(1'b1);
        for (int c = 0; c < 10 && expq.size() > 0; c++) begin
            tick(rdy, rv, rd);
            if (rv) begin
                exp = expq.pop_front();
                checks++;
                if (rd !== exp) begin
                    errors++;
                    $display("FAIL rand_drain c=%0d: got %h expected %h", c, rd, exp);
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rand_timeout: got %0d pending expected 0", expq.size());
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        for (int i = 0; i < NW; i++) begin
            w = {$urandom, $urandom};
            smem[i]   = w;
            refmem[i] = w;
        end
        smem[5]   = 64'hA5A5;
        refmem[5] = 64'hA5A5;
        smem[7]   = 64'h1122334455667788;
        refmem[7] = 64'h1122334455667788;
        test_reset();
        test_single_read();
        test_streaming();
        test_backpressure();
        test_write_read();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
